intt_gs_butterfly: RTL and testbench
====================================

Name: intt_gs_butterfly

Overview:
- Pipelined Gentleman-Sande (inverse-NTT) butterfly for the Dilithium field, Q = 8380417.
- It is the inverse-direction counterpart of the forward butterfly datapath built from the existing mod add/sub/mult units.
- Computes u = (a+b) mod Q and v = ((a−b)·w) mod Q, with optional per-layer halving (x/2 mod Q) that folds the 1/N scaling into the layers.
- Sits between the INTT address/twiddle controller and the coefficient RAM write-back; a tag field carries the write-back address alongside the data.

Parameters:
- Q, 23'd8380417, field modulus.
- WIDTH, 23, coefficient width.
- TAG_W, 8, width of the pass-through tag (RAM address).
- MULT_LAT, 5, latency of the mod_mult instance; fixed at 5.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_a  in  WIDTH  top coefficient; must be < Q.
- in_b  in  WIDTH  bottom coefficient; must be < Q.
- in_w  in  WIDTH  inverse twiddle; must be < Q.
- in_half  in  1  apply x/2 mod Q to both outputs.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result beat present.
- out_u  out  WIDTH  (a+b)[/2] mod Q.
- out_v  out  WIDTH  ((a−b)·w)[/2] mod Q.
- out_tag  out  TAG_W  tag of this beat.
- busy  out  1  one or more beats in flight.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Flow control: none. A beat is accepted every cycle in_valid=1, with no backpressure and no stall. Throughput is 1 beat/clk.
- Latency: LAT = MULT_LAT + 2 = 7 cycles. A beat sampled at edge k appears on the outputs after edge k+7.
- Stage S0 (1 cycle): register raw a+b (WIDTH+1 bits) and a−b (WIDTH+1 bits, signed by MSB). Correction is combinational after the register:
  - sum: subtract Q if sum ≥ Q.
  - diff: add Q if MSB=1.
  - Both corrected results are in [0, Q−1].
- Stages S1..S5: the corrected diff and the w delayed by 1 cycle feed mod_mult. The corrected sum, half, tag and valid travel through MULT_LAT matched delay registers.
- Stage S6 (output register): for each of u and v, if half=1 then x/2 mod Q = (x>>1) + (x[0] ? (Q+1)/2 : 0); otherwise x unchanged. The result is always < Q.
- Valid pipeline: a LAT-deep shift register. out_valid is its tail. Bubbles (in_valid=0) are preserved exactly.
- Output data when out_valid=0 is don't-care, but must be stable (registered, not X after the first reset).
- busy: OR of all valid-pipeline bits, registered-equivalent. It drops to 0 exactly one cycle after the last out_valid=1.
- Reset values:
  - Immediately on rst assertion: out_valid=0, out_u=0, out_v=0, out_tag=0, busy=0, and all valid-pipeline bits = 0.
  - Internal data and tag regs need no reset.
- Reset mid-operation: every in-flight beat is discarded and never emitted. The first beat presented in the cycle after rst deasserts emerges LAT cycles later.
- Inputs ≥ Q: outputs undefined; there is no assertion in RTL.
- Simultaneous in_valid and out_valid: independent, with no interaction.

Decomposition:
- Shared package ntt_pkg holds: Q, WIDTH, HALF_Q = (Q+1)>>1, MULT_LAT = 5, and the coefficient type (WIDTH-bit).
- Sub-module mod_half: combinational x/2 mod Q, reused for u and v. It is also usable by the forward path's final scaling.
- Reuse existing units:
  - mod_mult is instantiated unchanged.
  - The add/sub stage is instantiated from mod_add/mod_sub or inlined, provided it is 1-cycle-equivalent.

Test Plan:
- a=5, b=3, w=2, half=0 -> after 7 clk: u=8, v=4. Same with half=1 -> u=4, v=2.
- a=3, b=5, w=1, half=0 -> u=8, v=8380415. Same with half=1 -> u=4, v=8380416 (odd halving path).
- a=b=8380416, w=1, half=0 -> u=8380415, v=0. a=1, b=0, w=8380416, half=1 -> u=4190209, v=4190208.
- Back-to-back 16 beats with random inputs and tags 0..15, interleaved with 3 single-cycle bubbles:
  - outputs match the reference model in order;
  - tags return in order;
  - bubbles appear at the same spacing;
  - busy falls one cycle after the last valid.
- rst asserted 3 cycles after 4 consecutive beats -> out_valid/outputs go 0 immediately and no beat is emitted. A new beat after deassert emerges exactly 7 cycles later.
- 10k random beats (inputs < Q, random half) against a golden model -> zero mismatches, with out_u and out_v always < Q.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and coefficient type for the Dilithium NTT datapath (Q = 8380417).
// Imported by the butterfly, the modular multiplier and the halving unit.
package ntt_pkg;

    localparam int unsigned WIDTH    = 23;
    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned LAT      = MULT_LAT + 2;

    typedef logic [WIDTH-1:0] coeff_t;

    localparam coeff_t Q      = 23'd8380417;
    localparam coeff_t HALF_Q = (Q + 23'd1) >> 1;

endpackage

// File: rtl/mod_half.sv
// Combinational x/2 mod Q for x < Q: odd values borrow (Q+1)/2 so the result stays < Q.
module mod_half
    import ntt_pkg::*;
(
    input  coeff_t x,
    output coeff_t y
);

    assign y = (x >> 1) + (x[0] ? HALF_Q : '0);

endmodule

// File: rtl/mod_mult.sv
// Five-stage pipelined (a*b) mod Q, reducing with 2^23 = 2^13 - 1 (mod Q).
// Inputs are captured on the first edge; the result appears after the fifth.
module mod_mult
    import ntt_pkg::*;
(
    input  logic   clk,
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t p
);

    logic [45:0] prod_q;
    logic [36:0] r1_q;
    logic [27:0] r2_q;
    logic [23:0] r3_q;
    coeff_t      p_q;

    // Each fold maps hi*2^23 + lo to hi*8191 + lo; three folds bring the value below 2Q.
    always_ff @(posedge clk) begin
        prod_q <= 46'(a) * 46'(b);
        r1_q   <= 37'(prod_q[45:23]) * 37'd8191 + 37'(prod_q[22:0]);
        r2_q   <= 28'(r1_q[36:23]) * 28'd8191 + 28'(r1_q[22:0]);
        r3_q   <= 24'(r2_q[27:23]) * 24'd8191 + 24'(r2_q[22:0]);
        p_q    <= (r3_q >= {1'b0, Q}) ? WIDTH'(r3_q - {1'b0, Q}) : r3_q[WIDTH-1:0];
    end

    assign p = p_q;

endmodule

// File: rtl/intt_gs_butterfly.sv
// Pipelined Gentleman-Sande inverse-NTT butterfly: u = (a+b) mod Q, v = ((a-b)*w) mod Q,
// with optional per-layer halving; 7-cycle latency, one beat per clock, tag passed through.
module intt_gs_butterfly
    import ntt_pkg::*;
#(
    parameter int unsigned TAG_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  coeff_t           in_a,
    input  coeff_t           in_b,
    input  coeff_t           in_w,
    input  logic             in_half,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output coeff_t           out_u,
    output coeff_t           out_v,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [WIDTH:0]   sum_raw_q;
    logic [WIDTH:0]   diff_raw_q;
    coeff_t           w_q;
    logic             half_q;
    logic [TAG_W-1:0] tag_q;

    coeff_t           sum_c;
    coeff_t           diff_c;
    coeff_t           prod;

    coeff_t           sum_dly  [MULT_LAT];
    logic             half_dly [MULT_LAT];
    logic [TAG_W-1:0] tag_dly  [MULT_LAT];

    coeff_t           u_half;
    coeff_t           v_half;

    logic [LAT-1:0]   vld_q;

    always_ff @(posedge clk) begin
        sum_raw_q  <= {1'b0, in_a} + {1'b0, in_b};
        diff_raw_q <= {1'b0, in_a} - {1'b0, in_b};
        w_q        <= in_w;
        half_q     <= in_half;
        tag_q      <= in_tag;
    end

    // The S0 register holds raw sum/difference; correction sits on its output path.
    always_comb begin
        sum_c  = (sum_raw_q >= {1'b0, Q}) ? WIDTH'(sum_raw_q - {1'b0, Q})
                                           : sum_raw_q[WIDTH-1:0];
        diff_c = diff_raw_q[WIDTH] ? WIDTH'(diff_raw_q + {1'b0, Q})
                                   : diff_raw_q[WIDTH-1:0];
    end

    mod_mult u_mult (
        .clk (clk),
        .a   (diff_c),
        .b   (w_q),
        .p   (prod)
    );

    always_ff @(posedge clk) begin
        sum_dly[0]  <= sum_c;
        half_dly[0] <= half_q;
        tag_dly[0]  <= tag_q;
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
            sum_dly[i]  <= sum_dly[i-1];
            half_dly[i] <= half_dly[i-1];
            tag_dly[i]  <= tag_dly[i-1];
        end
    end

    mod_half u_half_u (
        .x (sum_dly[MULT_LAT-1]),
        .y (u_half)
    );

    mod_half u_half_v (
        .x (prod),
        .y (v_half)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], in_valid};
        end
    end

    // Output data only updates for real beats, so it holds steady across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_u   <= '0;
            out_v   <= '0;
            out_tag <= '0;
        end else if (vld_q[LAT-2]) begin
            out_u   <= half_dly[MULT_LAT-1] ? u_half : sum_dly[MULT_LAT-1];
            out_v   <= half_dly[MULT_LAT-1] ? v_half : prod;
            out_tag <= tag_dly[MULT_LAT-1];
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign busy      = |vld_q;

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Scoreboard bench for intt_gs_butterfly: stimulus queues expected beats with their due
// cycle; a negedge monitor checks valid, busy, data and tag against the queue head.
module tb_intt_gs_butterfly;
    import ntt_pkg::*;

    localparam int unsigned TB_TAG_W = 8;
    localparam longint      QL       = 64'd8380417;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    coeff_t              in_a, in_b, in_w;
    logic                in_half;
    logic [TB_TAG_W-1:0] in_tag;
    logic                out_valid;
    coeff_t              out_u, out_v;
    logic [TB_TAG_W-1:0] out_tag;
    logic                busy;

    intt_gs_butterfly #(.TAG_W(TB_TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_half   (in_half),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_u     (out_u),
        .out_v     (out_v),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    typedef struct {
        longint              due;
        longint              u;
        longint              v;
        logic [TB_TAG_W-1:0] tag;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    int     next_tag = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint halve(input longint x, input bit h);
        if (!h) return x;
        return (x % 2 == 1) ? (x + QL) / 2 : x / 2;
    endfunction

    function automatic longint model_u(input longint a, input longint b, input bit h);
        return halve((a + b) % QL, h);
    endfunction

    function automatic longint model_v(input longint a, input longint b, input longint w,
                                       input bit h);
        return halve((((a - b + QL) % QL) * w) % QL, h);
    endfunction

    task automatic send(input longint a, input longint b, input longint w, input bit h,
                        input logic [TB_TAG_W-1:0] tag, input longint eu, input longint ev);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = WIDTH'(a);
        in_b     = WIDTH'(b);
        in_w     = WIDTH'(w);
        in_half  = h;
        in_tag   = tag;
        e.due    = cyc + 7;
        e.u      = eu;
        e.v      = ev;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic send_rand();
        longint a, b, w;
        bit     h;
        a = longint'($urandom_range(0, 8380416));
        b = longint'($urandom_range(0, 8380416));
        w = longint'($urandom_range(0, 8380416));
        h = 1'($urandom_range(0, 1));
        send(a, b, w, h, TB_TAG_W'(next_tag), model_u(a, b, h), model_v(a, b, w, h));
        next_tag++;
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            bubble();
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) bubble();
    endtask

    always @(negedge clk) begin
        bit   exp_v, exp_b;
        exp_t e;
        if (rst) begin
            check("rst_out_valid", longint'(out_valid), 0);
            check("rst_busy", longint'(busy), 0);
        end else begin
            exp_v = (sb.size() != 0) && (sb[0].due == cyc);
            exp_b = (sb.size() != 0) && (sb[0].due <= cyc + 6);
            check("out_valid", longint'(out_valid), longint'(exp_v));
            check("busy", longint'(busy), longint'(exp_b));
            if (out_valid) begin
                check("u_below_q", longint'(out_u < Q), 1);
                check("v_below_q", longint'(out_v < Q), 1);
            end
            if (exp_v) begin
                e = sb.pop_front();
                if (out_valid) begin
                    check("out_u", longint'(out_u), e.u);
                    check("out_v", longint'(out_v), e.v);
                    check("out_tag", longint'(out_tag), longint'(e.tag));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_w     = '0;
        in_half  = 1'b0;
        in_tag   = '0;
        #2 rst = 1'b1;
        #1;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_u", longint'(out_u), 0);
        check("reset_out_v", longint'(out_v), 0);
        check("reset_out_tag", longint'(out_tag), 0);
        check("reset_busy", longint'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors with hand-computed results
        send(5, 3, 2, 1'b0, 8'd1, 8, 4);
        send(5, 3, 2, 1'b1, 8'd2, 4, 2);
        send(3, 5, 1, 1'b0, 8'd3, 8, 8380415);
        send(3, 5, 1, 1'b1, 8'd4, 4, 8380416);
        send(8380416, 8380416, 1, 1'b0, 8'd5, 8380415, 0);
        send(1, 0, 8380416, 1'b1, 8'd6, 4190209, 4190208);
        drain();

        // 16 back-to-back beats with three single-cycle bubbles
        next_tag = 0;
        for (int i = 0; i < 19; i++) begin
            if (i == 4 || i == 9 || i == 14) bubble();
            else send_rand();
        end
        drain();

        // Reset in the middle of a burst: nothing in flight may emerge
        next_tag = 100;
        repeat (4) send_rand();
        repeat (3) bubble();
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_u", longint'(out_u), 0);
        check("midrst_out_v", longint'(out_v), 0);
        check("midrst_out_tag", longint'(out_tag), 0);
        check("midrst_busy", longint'(busy), 0);
        repeat (2) bubble();
        @(posedge clk);
        #1 rst = 1'b0;
        send(7, 2, 3, 1'b0, 8'd200, 9, 15);
        drain();

        // Long random run with random bubbles
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) < 8) send_rand();
            else bubble();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
